cache_axi_read_arbiter: RTL and testbench
=========================================

Name: cache_axi_read_arbiter

Overview:
- Shares one AXI read channel (AR/R) between the instruction-cache refill path and the data-cache refill/uncached path.
- Arbitrates round-robin between the two requesters, issues one AR burst at a time and steers the returning R beats to the owner.
- Feeds the owner's rdata/rvalid into its cache; the instruction side connects directly to the inst_cache axi_rdata/axi_rvalid inputs.
- One transaction outstanding at a time; no reordering.

Parameters:
INST_ID, 0, ARID driven for instruction requests
DATA_ID, 1, ARID driven for data requests
ARSIZE, 3'b010, fixed beat size (4 bytes)
ARBURST, 2'b01, fixed burst type (INCR)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  instruction refill request; held high until inst_grant
inst_addr  in  32  burst start address; stable while inst_req is high
inst_len  in  8  AXI arlen encoding (beats-1)
inst_grant  out  1  pulse on the AR handshake of an instruction burst
inst_rdata  out  32  beat data
inst_rvalid  out  1  beat valid for the instruction side
inst_rlast  out  1  last beat for the instruction side
data_req, data_addr, data_len, data_grant, data_rdata, data_rvalid, data_rlast  same widths/meaning for the data side
arid  out  4  read ID
araddr  out  32  read address
arlen  out  8  burst length
arsize  out  3  = ARSIZE
arburst  out  2  = ARBURST
arvalid  out  1  address valid
arready  in  1  address ready
rid  in  4  response ID
rdata  in  32  response data
rresp  in  2  response status
rlast  in  1  last beat
rvalid  in  1  beat valid
rready  out  1  beat ready
resp_err  out  1  one-cycle pulse on a protocol or response error

Behaviour:
- Reset (async, resetn=0):
  - State IDLE.
  - arvalid=0, rready=0; all grant, rvalid, rlast outputs 0; resp_err=0.
  - Latched addr/len/id = 0; round-robin pointer favours data.
  - All outputs 0 while in reset.
- FSM IDLE:
  - If inst_req or data_req is high, select the winner:
    - Only one request high: that requester wins.
    - Both high: the pointer's favourite wins.
  - Latch the winner's addr, len and id plus an owner flag, then go to AR.
  - arvalid rises in the cycle after req is first seen (1-cycle latency).
- FSM AR:
  - arvalid=1 with the latched values held stable.
  - On arvalid&arready: pulse the owner's grant in that same cycle (combinational), clear the beat counter, go to R.
  - arvalid stays high indefinitely while arready=0. It is never withdrawn.
- FSM R:
  - rready=1.
  - owner_rvalid = rvalid; owner_rlast = rlast&rvalid.
  - Both inst_rdata and data_rdata = rdata, combinational pass-through.
  - The non-owner's rvalid/rlast stay 0.
  - Beat counter (8 bits) increments on each rvalid.
  - On rvalid&rlast: go to IDLE and set the pointer to favour the non-owner.
- Errors (resp_err pulses in the offending beat cycle; data is still forwarded):
  - rresp != 0 on any beat.
  - rid != latched id.
  - rlast arrives with counter != latched len (early).
  - counter == len and rlast=0 (late); R continues until rlast arrives.
- Requester handshake:
  - Requests are sampled only in IDLE.
  - A requester that drops req before grant is undefined usage; the latched transaction is still issued.
  - Requests arriving during AR or R wait.
  - The minimum gap between bursts is one IDLE cycle after the rlast beat.
- Starvation: with both sides requesting continuously, grants alternate strictly.
- Reset mid-operation:
  - Immediate return to IDLE; arvalid and rready drop asynchronously.
  - The AXI slave shares the reset; no partial transaction is resumed.
- Flush in a cache does not abort a burst. All beats are delivered and the cache discards them.

Test Plan:
- Inst only: inst_req, addr=0x1FC0_0000, len=7 → arvalid 1 cycle later, arid=0, arlen=7, arsize=2, arburst=1; 8 beats on inst_rvalid; inst_rlast on the 8th; data_rvalid stays 0; back to IDLE.
- Simultaneous after reset: both req, inst_addr=0x100, data_addr=0x200 → data granted first (araddr=0x200, arid=1), then inst (0x100). Repeat both req → inst granted first.
- AR backpressure: arready held low 5 cycles → arvalid high for 6 cycles, araddr/arlen unchanged, no grant until the handshake cycle, grant exactly 1 cycle.
- R gaps: len=3 with rvalid low between each beat → exactly 4 owner rvalid pulses, rdata values passed unchanged (0xA0..0xA3), resp_err=0.
- Errors: len=3 but rlast on beat 2 → resp_err pulse on beat 2 and return to IDLE. Separate burst with rresp=2'b10 on beat 1 → resp_err pulse on that beat only.
- Reset during R after 2 of 8 beats → arvalid/rready/rvalid outputs 0 immediately. After release, a new inst request is issued normally with counter restarted.

Source files
------------

// File: rtl/cache_axi_read_arbiter_if.sv
// AXI read channel (AR + R) between the cache read arbiter and the shared
// AXI slave port. The arbiter drives AR and rready through the master modport.
interface cache_axi_read_arbiter_if;
  // Address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cache_axi_read_arbiter.sv
// Shares one AXI read channel between the instruction-cache refill path and
// the data-cache refill/uncached path. Round-robin arbitration, one burst in
// flight at a time, R beats steered to the owner of the current burst.
module cache_axi_read_arbiter #(
  parameter int         INST_ID = 0,
  parameter int         DATA_ID = 1,
  parameter logic [2:0] ARSIZE  = 3'b010,
  parameter logic [1:0] ARBURST = 2'b01
) (
  input  logic        clk,
  input  logic        resetn,
  // Instruction-cache requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  output logic        inst_grant,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  // Data-cache requester
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [7:0]  data_len,
  output logic        data_grant,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,
  // Shared AXI read channel
  cache_axi_read_arbiter_if.master axi,
  // Protocol / response error strobe
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [3:0] INST_ID_W = 4'(INST_ID);
  localparam logic [3:0] DATA_ID_W = 4'(DATA_ID);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [3:0]  r_id;
  logic        r_owner_data;   // 1: current burst belongs to the data side
  logic        r_prefer_data;  // round-robin pointer: 1 favours data on a tie
  logic [7:0]  r_cnt;          // beats received in the current burst
  logic        r_arvalid;
  logic        r_rready;

  logic        w_any_req;
  logic        w_pick_data;
  logic        w_ar_fire;
  logic        w_in_r;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_err;

  assign w_any_req   = inst_req | data_req;
  // Data wins when it is the only requester, or on a tie when favoured.
  assign w_pick_data = data_req & (~inst_req | r_prefer_data);
  assign w_ar_fire   = (r_state == S_AR) & r_arvalid & axi.arready;
  assign w_in_r      = (r_state == S_R);
  assign w_beat      = w_in_r & axi.rvalid;
  assign w_last_beat = w_beat & axi.rlast;

  // Error decode for the beat currently on the R channel.
  always_comb begin
    // NOTE: default first so no path through the block leaves w_err unassigned; otherwise a latch is inferred.
    w_err = 1'b0;
    if (w_beat) begin
      if (axi.rresp != 2'b00)               w_err = 1'b1;  // slave reported an error
      if (axi.rid != r_id)                  w_err = 1'b1;  // response for someone else
      if (axi.rlast && (r_cnt != r_len))    w_err = 1'b1;  // burst ended early (or late)
      if (!axi.rlast && (r_cnt == r_len))   w_err = 1'b1;  // expected last beat missing
    end
  end

  // Arbitration FSM: latch the winner, hold AR until accepted, drain R beats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Latched payload is reset too, so AR outputs read zero out of reset.
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_id          <= '0;
      r_owner_data  <= 1'b0;
      r_prefer_data <= 1'b1;
      r_cnt         <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_data <= w_pick_data;
            r_addr       <= w_pick_data ? data_addr : inst_addr;
            r_len        <= w_pick_data ? data_len  : inst_len;
            r_id         <= w_pick_data ? DATA_ID_W : INST_ID_W;
            r_arvalid    <= 1'b1;
            r_state      <= S_AR;
          end
        end

        S_AR: begin
          // arvalid is never withdrawn once raised; wait for the slave.
          if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_R;
          end
        end

        S_R: begin
          if (axi.rvalid) begin
            r_cnt <= r_cnt + 8'd1;
            // Only rlast closes the burst; a late rlast keeps us here.
            if (axi.rlast) begin
              r_rready      <= 1'b0;
              r_prefer_data <= ~r_owner_data;
              r_state       <= S_IDLE;
            end
          end
        end

        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // AXI address channel: latched values, fixed size and burst type.
  assign axi.arid    = r_id;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = r_len;
  assign axi.arsize  = ARSIZE;
  assign axi.arburst = ARBURST;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  // Grants pulse in the AR handshake cycle itself.
  assign inst_grant  = w_ar_fire & ~r_owner_data;
  assign data_grant  = w_ar_fire &  r_owner_data;

  // Beat steering: only the owner sees valid/last; data is shared.
  assign inst_rvalid = w_beat      & ~r_owner_data;
  assign inst_rlast  = w_last_beat & ~r_owner_data;
  assign data_rvalid = w_beat      &  r_owner_data;
  assign data_rlast  = w_last_beat &  r_owner_data;
  assign inst_rdata  = w_in_r ? axi.rdata : '0;
  assign data_rdata  = w_in_r ? axi.rdata : '0;

  assign resp_err    = w_err;

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Directed bench for cache_axi_read_arbiter: the bench plays the AXI slave
// and both requesters, with hand-computed expectations per scenario.
module tb_cache_axi_read_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [7:0]  inst_len;
  logic        inst_grant;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_rlast;
  logic        data_req;
  logic [31:0] data_addr;
  logic [7:0]  data_len;
  logic        data_grant;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        data_rlast;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  cache_axi_read_arbiter_if axi ();

  cache_axi_read_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_len    (inst_len),
    .inst_grant  (inst_grant),
    .inst_rdata  (inst_rdata),
    .inst_rvalid (inst_rvalid),
    .inst_rlast  (inst_rlast),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_len    (data_len),
    .data_grant  (data_grant),
    .data_rdata  (data_rdata),
    .data_rvalid (data_rvalid),
    .data_rlast  (data_rlast),
    .axi         (axi.master),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'd0;
    axi.rresp   = 2'b00;
  endtask

  // Bounded wait for arvalid; leaves the caller at the falling edge where it was seen.
  task automatic wait_arvalid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.arvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL arvalid_timeout: arvalid still low after 20 cycles, required 1");
      finish_tb();
    end
  endtask

  // Accept one AR after low_cycles of backpressure and check fields/grant.
  task automatic do_ar(input bit exp_data, input logic [31:0] exp_addr,
                       input logic [7:0] exp_len, input int low_cycles);
    logic [3:0] exp_id;
    int         hi;
    exp_id = exp_data ? 4'd1 : 4'd0;
    hi = 0;
    wait_arvalid();
    for (int i = 0; i < low_cycles; i++) begin
      if (i > 0) begin
        next_cycle();
        @(negedge clk);
      end
      if (axi.arvalid === 1'b1) hi++;
      checks++;
      if ({axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} !==
          {exp_id, exp_addr, exp_len, 3'b010, 2'b01}) begin
        failures++;
        $display("FAIL ar_fields: got id=%0d addr=%h len=%0d size=%0d burst=%0d, required id=%0d addr=%h len=%0d size=2 burst=1",
                 axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, exp_id, exp_addr, exp_len);
      end
      checks++;
      if ({inst_grant, data_grant} !== 2'b00) begin
        failures++;
        $display("FAIL grant_early: got inst=%b data=%b before handshake, required 0 0", inst_grant, data_grant);
      end
    end
    next_cycle();
    axi.arready = 1'b1;
    @(negedge clk);
    if (axi.arvalid === 1'b1) hi++;
    checks++;
    if ({inst_grant, data_grant} !== (exp_data ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL grant_owner: got inst=%b data=%b, required inst=%b data=%b",
               inst_grant, data_grant, !exp_data, exp_data);
    end
    checks++;
    if (hi != low_cycles + 1) begin
      failures++;
      $display("FAIL arvalid_cycles: got %0d cycles high, required %0d", hi, low_cycles + 1);
    end
    next_cycle();
    axi.arready = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.arvalid, axi.rready, inst_grant, data_grant} !== 4'b0100) begin
      failures++;
      $display("FAIL after_ar: got arvalid=%b rready=%b grants=%b%b, required arvalid=0 rready=1 grants=00",
               axi.arvalid, axi.rready, inst_grant, data_grant);
    end
    next_cycle();
  endtask

  // Drive R beats; the error expectation uses the bench's own beat index.
  task automatic run_burst(input bit own_data, input logic [3:0] rid_v, input logic [3:0] exp_id,
                           input logic [7:0] len, input int nbeats, input int rlast_beat,
                           input int bad_beat, input int gap, input logic [31:0] base,
                           input bit expect_idle, output int pulses);
    logic        own_v, oth_v, own_l, oth_l, last_b, exp_err;
    logic [31:0] own_d;
    pulses = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        @(negedge clk);
        if ((own_data ? data_rvalid : inst_rvalid) === 1'b1) pulses++;
        checks++;
        if ({inst_rvalid, data_rvalid, resp_err, axi.rready} !== 4'b0001) begin
          failures++;
          $display("FAIL gap_cycle: got irv=%b drv=%b err=%b rready=%b, required 0 0 0 1",
                   inst_rvalid, data_rvalid, resp_err, axi.rready);
        end
        next_cycle();
      end
      last_b      = (b == rlast_beat);
      axi.rvalid  = 1'b1;
      axi.rid     = rid_v;
      axi.rdata   = base + 32'(b);
      axi.rlast   = last_b;
      axi.rresp   = (b == bad_beat) ? 2'b10 : 2'b00;
      exp_err     = (b == bad_beat) || (rid_v != exp_id) ||
                    (last_b && (b != int'(len))) || (!last_b && (b == int'(len)));
      @(negedge clk);
      own_v = own_data ? data_rvalid : inst_rvalid;
      oth_v = own_data ? inst_rvalid : data_rvalid;
      own_l = own_data ? data_rlast  : inst_rlast;
      oth_l = own_data ? inst_rlast  : data_rlast;
      own_d = own_data ? data_rdata  : inst_rdata;
      if (own_v === 1'b1) pulses++;
      checks++;
      if ({own_v, oth_v, own_l, oth_l, axi.rready} !== {1'b1, 1'b0, last_b, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL beat_ctrl b%0d: got own_v=%b oth_v=%b own_l=%b oth_l=%b rready=%b, required 1 0 %b 0 1",
                 b, own_v, oth_v, own_l, oth_l, axi.rready, last_b);
      end
      checks++;
      if (own_d !== base + 32'(b)) begin
        failures++;
        $display("FAIL beat_data b%0d: got %h, required %h", b, own_d, base + 32'(b));
      end
      checks++;
      if (resp_err !== exp_err) begin
        failures++;
        $display("FAIL resp_err b%0d: got %b, required %b", b, resp_err, exp_err);
      end
      next_cycle();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    if (expect_idle) begin
      @(negedge clk);
      checks++;
      if ({axi.rready, axi.arvalid, inst_rvalid, data_rvalid, resp_err} !== 5'b0) begin
        failures++;
        $display("FAIL back_to_idle: got rready=%b arvalid=%b irv=%b drv=%b err=%b, required all 0",
                 axi.rready, axi.arvalid, inst_rvalid, data_rvalid, resp_err);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    inst_req  = 1'b1;
    inst_addr = 32'hDEAD_BEEF;
    inst_len  = 8'd5;
    data_req  = 1'b1;
    data_addr = 32'h1234_5678;
    data_len  = 8'd2;
    slave_idle();
    axi.rvalid = 1'b1;
    axi.rdata  = 32'hFFFF_FFFF;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({axi.arvalid, axi.rready, inst_grant, data_grant, inst_rvalid, data_rvalid,
         inst_rlast, data_rlast, resp_err} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got arv=%b rr=%b ig=%b dg=%b irv=%b drv=%b irl=%b drl=%b err=%b, required all 0",
               axi.arvalid, axi.rready, inst_grant, data_grant, inst_rvalid, data_rvalid,
               inst_rlast, data_rlast, resp_err);
    end
    checks++;
    if ({axi.arid, axi.araddr, axi.arlen, inst_rdata, data_rdata} !== 108'b0) begin
      failures++;
      $display("FAIL reset_payload: got id=%0d addr=%h len=%0d irdata=%h drdata=%h, required all 0",
               axi.arid, axi.araddr, axi.arlen, inst_rdata, data_rdata);
    end
    next_cycle();
    inst_req = 1'b0;
    data_req = 1'b0;
    slave_idle();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_inst_only();
    int p;
    inst_req  = 1'b1;
    inst_addr = 32'h1FC0_0000;
    inst_len  = 8'd7;
    @(negedge clk);
    checks++;
    if (axi.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL ar_latency: got arvalid=%b in the request cycle, required 0", axi.arvalid);
    end
    next_cycle();
    do_ar(1'b0, 32'h1FC0_0000, 8'd7, 1);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd7, 8, 7, -1, 0, 32'h1000_0000, 1'b1, p);
    checks++;
    if (p != 8) begin
      failures++;
      $display("FAIL inst_pulses: got %0d inst_rvalid pulses, required 8", p);
    end
  endtask

  task automatic test_round_robin();
    int p;
    bit exp_data;
    resetn = 1'b0;
    next_cycle();
    resetn    = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    inst_len  = 8'd1;
    data_req  = 1'b1;
    data_addr = 32'h0000_0200;
    data_len  = 8'd1;
    // Both sides request continuously: data, inst, data, inst.
    for (int k = 0; k < 4; k++) begin
      exp_data = ((k % 2) == 0);
      do_ar(exp_data, exp_data ? 32'h0000_0200 : 32'h0000_0100, 8'd1, 1);
      if (k == 3) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      run_burst(exp_data, exp_data ? 4'd1 : 4'd0, exp_data ? 4'd1 : 4'd0, 8'd1, 2, 1, -1, 0,
                32'h5000_0000 + 32'(k * 16), 1'b1, p);
    end
  endtask

  task automatic test_ar_backpressure();
    int p;
    inst_req  = 1'b1;
    inst_addr = 32'h2000_0040;
    inst_len  = 8'd2;
    do_ar(1'b0, 32'h2000_0040, 8'd2, 5);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd2, 3, 2, -1, 0, 32'h6000_0000, 1'b1, p);
  endtask

  task automatic test_r_gaps();
    int p;
    data_req  = 1'b1;
    data_addr = 32'h3000_0000;
    data_len  = 8'd3;
    do_ar(1'b1, 32'h3000_0000, 8'd3, 1);
    data_req = 1'b0;
    run_burst(1'b1, 4'd1, 4'd1, 8'd3, 4, 3, -1, 1, 32'h0000_00A0, 1'b1, p);
    checks++;
    if (p != 4) begin
      failures++;
      $display("FAIL gap_pulses: got %0d data_rvalid pulses, required 4", p);
    end
  endtask

  task automatic test_errors();
    int p;
    // Early rlast on beat 2 of a 4-beat burst.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_1000;
    inst_len  = 8'd3;
    do_ar(1'b0, 32'h0000_1000, 8'd3, 1);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd3, 3, 2, -1, 0, 32'h7000_0000, 1'b1, p);
    // SLVERR on beat 1 only.
    data_req  = 1'b1;
    data_addr = 32'h0000_2000;
    data_len  = 8'd3;
    do_ar(1'b1, 32'h0000_2000, 8'd3, 1);
    data_req = 1'b0;
    run_burst(1'b1, 4'd1, 4'd1, 8'd3, 4, 3, 1, 0, 32'h7100_0000, 1'b1, p);
    // Wrong rid on a single-beat burst.
    data_addr = 32'h0000_2100;
    data_len  = 8'd0;
    data_req  = 1'b1;
    do_ar(1'b1, 32'h0000_2100, 8'd0, 1);
    data_req = 1'b0;
    run_burst(1'b1, 4'd0, 4'd1, 8'd0, 1, 0, -1, 0, 32'h7200_0000, 1'b1, p);
    // Late rlast: len=1 but rlast on beat 2.
    inst_addr = 32'h0000_3000;
    inst_len  = 8'd1;
    inst_req  = 1'b1;
    do_ar(1'b0, 32'h0000_3000, 8'd1, 1);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd1, 3, 2, -1, 0, 32'h7300_0000, 1'b1, p);
  endtask

  task automatic test_reset_mid_r();
    int p;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_4000;
    inst_len  = 8'd7;
    do_ar(1'b0, 32'h0000_4000, 8'd7, 1);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd7, 2, -1, -1, 0, 32'h8000_0000, 1'b0, p);
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h8000_0002;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({axi.arvalid, axi.rready, inst_rvalid, inst_rlast, data_rvalid, resp_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_r: got arv=%b rr=%b irv=%b irl=%b drv=%b err=%b, required all 0",
               axi.arvalid, axi.rready, inst_rvalid, inst_rlast, data_rvalid, resp_err);
    end
    next_cycle();
    slave_idle();
    resetn    = 1'b1;
    inst_addr = 32'h0000_5000;
    inst_len  = 8'd1;
    inst_req  = 1'b1;
    do_ar(1'b0, 32'h0000_5000, 8'd1, 1);
    inst_req = 1'b0;
    run_burst(1'b0, 4'd0, 4'd0, 8'd1, 2, 1, -1, 0, 32'h9000_0000, 1'b1, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inst_only();
    test_round_robin();
    test_ar_backpressure();
    test_r_gaps();
    test_errors();
    test_reset_mid_r();
    finish_tb();
  end

endmodule
